decomp_fetch_arbiter: RTL and testbench

Round-robin arbiter that shares one registered instruction decompressor (compressed-image + token-table lookup, PC in / 32-bit instruction out) between two CPU fetch requesters. It grants at most one PC per cycle, tracks every in-flight lookup with a requester-tag pipeline matched to the decompressor latency, and routes each decompressed instruction back to its owner. Per-requester flush drops stale lookups after a branch redirect. It sits between the fetch stages of both cores and the single shared decompressor instance.

---
 rtl/decomp_fetch_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_decomp_fetch_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decomp_fetch_arbiter.sv
// decomp_fetch_arbiter
// Shares one registered instruction decompressor between two fetch
// requesters. A round-robin grant issues at most one PC per cycle, a
// requester-tag pipeline matched to the decompressor latency follows each
// lookup, and the returning instruction is steered back to its owner.
// Per-requester flush drops stale lookups after a branch redirect.
// Optional feature: define DECOMP_ARB_STATS_EN to add the saturating
// per-requester grant counters gnt_cnt0_o / gnt_cnt1_o.
module decomp_fetch_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int DEC_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req_i,
    input  logic [ADDR_W-1:0]  pc0_i,
    input  logic [ADDR_W-1:0]  pc1_i,
    input  logic [1:0]         flush_i,
    output logic [1:0]         gnt_o,
    output logic [ADDR_W-1:0]  dec_pc_o,
    input  logic [INSTR_W-1:0] dec_instr_i,
    output logic [1:0]         rsp_valid_o,
    output logic [INSTR_W-1:0] rsp_instr_o,
`ifdef DECOMP_ARB_STATS_EN
    output logic [31:0]        gnt_cnt0_o,
    output logic [31:0]        gnt_cnt1_o,
`endif
    output logic               busy_o
);

    logic                r_rr_ptr;
    logic [ADDR_W-1:0]   r_last_pc;
    logic [DEC_LAT-1:0]  r_tag_valid;
    logic [DEC_LAT-1:0]  r_tag_id;
    logic                r_rsp_pend;
    logic                r_rsp_id;
    logic [INSTR_W-1:0]  r_rsp_data;
    logic [INSTR_W-1:0]  r_rsp_hold;

    logic [1:0]          w_elig;
    logic [1:0]          w_gnt;
    logic                w_gnt_id;
    logic [DEC_LAT-1:0]  w_tag_valid_nxt;
    logic [DEC_LAT-1:0]  w_tag_id_nxt;
    logic                w_exit_valid;
    logic                w_deliver;

    // Round-robin grant: a flushing requester is never eligible, reset blocks all grants
    always_comb begin
        w_elig   = req_i & ~flush_i;
        w_gnt    = 2'b00;
        w_gnt_id = 1'b0;
        if (reset) begin
            w_gnt    = 2'b00;
            w_gnt_id = 1'b0;
        end else begin
            case (w_elig)
                2'b01: begin
                    w_gnt    = 2'b01;
                    w_gnt_id = 1'b0;
                end
                2'b10: begin
                    w_gnt    = 2'b10;
                    w_gnt_id = 1'b1;
                end
                2'b11: begin
                    if (r_rr_ptr) begin
                        w_gnt    = 2'b10;
                        w_gnt_id = 1'b1;
                    end else begin
                        w_gnt    = 2'b01;
                        w_gnt_id = 1'b0;
                    end
                end
                default: begin
                    w_gnt    = 2'b00;
                    w_gnt_id = 1'b0;
                end
            endcase
        end
    end

    // Decompressor PC: granted PC this cycle, otherwise the last one issued
    always_comb begin
        if (w_gnt[1]) begin
            dec_pc_o = pc1_i;
        end else if (w_gnt[0]) begin
            dec_pc_o = pc0_i;
        end else begin
            dec_pc_o = r_last_pc;
        end
    end

    // Next tag-pipeline contents: shift by one, killing tags of flushing requesters
    always_comb begin
        w_tag_valid_nxt    = '0;
        w_tag_id_nxt       = '0;
        w_tag_valid_nxt[0] = |w_gnt;
        w_tag_id_nxt[0]    = w_gnt_id;
        for (int i = 1; i < DEC_LAT; i++) begin
            w_tag_valid_nxt[i] = r_tag_valid[i-1] & ~flush_i[r_tag_id[i-1]];
            w_tag_id_nxt[i]    = r_tag_id[i-1];
        end
        w_exit_valid = r_tag_valid[DEC_LAT-1] & ~flush_i[r_tag_id[DEC_LAT-1]];
    end

    // Response strobe: the captured result can still be cancelled by flush in its delivery cycle
    always_comb begin
        w_deliver = r_rsp_pend & ~flush_i[r_rsp_id] & ~reset;
        if (w_deliver) begin
            rsp_valid_o = r_rsp_id ? 2'b10 : 2'b01;
            rsp_instr_o = r_rsp_data;
        end else begin
            rsp_valid_o = 2'b00;
            rsp_instr_o = r_rsp_hold;
        end
        gnt_o  = w_gnt;
        busy_o = |r_tag_valid;
    end

    // Arbiter state, tag pipeline and response capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr    <= 1'b0;
            r_last_pc   <= '0;
            r_tag_valid <= '0;
            r_tag_id    <= '0;
            r_rsp_pend  <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_hold  <= '0;
        end else begin
            r_tag_valid <= w_tag_valid_nxt;
            r_tag_id    <= w_tag_id_nxt;
            r_rsp_pend  <= w_exit_valid;
            r_rsp_id    <= r_tag_id[DEC_LAT-1];
            r_rsp_hold  <= rsp_instr_o;
            if (|w_gnt) begin
                r_rr_ptr  <= ~w_gnt_id;
                r_last_pc <= dec_pc_o;
            end else begin
                r_rr_ptr  <= r_rr_ptr;
                r_last_pc <= r_last_pc;
            end
            if (w_exit_valid) begin
                r_rsp_data <= dec_instr_i;
            end else begin
                r_rsp_data <= r_rsp_data;
            end
        end
    end

`ifdef DECOMP_ARB_STATS_EN
    logic [31:0] r_gnt_cnt0;
    logic [31:0] r_gnt_cnt1;

    // Saturating grant counters per requester
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt_cnt0 <= 32'd0;
            r_gnt_cnt1 <= 32'd0;
        end else begin
            if (w_gnt[0] && (r_gnt_cnt0 != 32'hFFFF_FFFF)) begin
                r_gnt_cnt0 <= r_gnt_cnt0 + 32'd1;
            end else begin
                r_gnt_cnt0 <= r_gnt_cnt0;
            end
            if (w_gnt[1] && (r_gnt_cnt1 != 32'hFFFF_FFFF)) begin
                r_gnt_cnt1 <= r_gnt_cnt1 + 32'd1;
            end else begin
                r_gnt_cnt1 <= r_gnt_cnt1;
            end
        end
    end

    assign gnt_cnt0_o = r_gnt_cnt0;
    assign gnt_cnt1_o = r_gnt_cnt1;
`endif

endmodule

// File: tb/tb_decomp_fetch_arbiter.sv
// Self-checking bench for decomp_fetch_arbiter. Two instances (latency 1 and
// 3) see identical stimulus; a transaction-history model predicts grants,
// responses, busy and the decompressor PC every cycle.
module tb_decomp_fetch_arbiter;

    localparam int MAXC = 512;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  flush;
    logic [31:0] pc0;
    logic [31:0] pc1;

    logic [1:0]  gnt1, gnt3, rv1, rv3;
    logic [31:0] dpc1, dpc3, din1, din3, ri1, ri3;
    logic        busy1, busy3;
`ifdef DECOMP_ARB_STATS_EN
    logic [31:0] c01, c11, c03, c13;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decomp_fetch_arbiter #(.ADDR_W(32), .INSTR_W(32), .DEC_LAT(1)) u_dut1 (
        .clk(clk), .reset(rst), .req_i(req), .pc0_i(pc0), .pc1_i(pc1),
        .flush_i(flush), .gnt_o(gnt1), .dec_pc_o(dpc1), .dec_instr_i(din1),
        .rsp_valid_o(rv1), .rsp_instr_o(ri1),
`ifdef DECOMP_ARB_STATS_EN
        .gnt_cnt0_o(c01), .gnt_cnt1_o(c11),
`endif
        .busy_o(busy1));

    decomp_fetch_arbiter #(.ADDR_W(32), .INSTR_W(32), .DEC_LAT(3)) u_dut3 (
        .clk(clk), .reset(rst), .req_i(req), .pc0_i(pc0), .pc1_i(pc1),
        .flush_i(flush), .gnt_o(gnt3), .dec_pc_o(dpc3), .dec_instr_i(din3),
        .rsp_valid_o(rv3), .rsp_instr_o(ri3),
`ifdef DECOMP_ARB_STATS_EN
        .gnt_cnt0_o(c03), .gnt_cnt1_o(c13),
`endif
        .busy_o(busy3));

    // Stub decompressor: word derived from the PC, delayed by the instance latency
    function automatic logic [31:0] stub(input logic [31:0] pc);
        return {pc[15:0], ~pc[15:0]};
    endfunction

    logic [31:0] p1;
    logic [31:0] p3a, p3b, p3c;
    always @(posedge clk) begin
        p1  <= dpc1;
        p3a <= dpc3;
        p3b <= p3a;
        p3c <= p3b;
    end
    assign din1 = stub(p1);
    assign din3 = stub(p3c);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // History of what the arbiter issued and what was killed, per cycle
    logic        g_v  [MAXC];
    logic        g_id [MAXC];
    logic [31:0] g_pc [MAXC];
    logic [1:0]  kill [MAXC];
    int          cyc = 0;

    function automatic bit alive(input int n, input int upto);
        for (int m = n + 1; m <= upto; m++) begin
            if (kill[m][g_id[n]]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [1:0] strobe(input int lat);
        int n;
        n = cyc - lat - 1;
        if (n < 0) return 2'b00;
        if (!g_v[n] || !alive(n, cyc)) return 2'b00;
        return g_id[n] ? 2'b10 : 2'b01;
    endfunction

    function automatic logic busy_exp(input int lat);
        for (int n = cyc - lat; n < cyc; n++) begin
            if (n >= 0 && g_v[n] && alive(n, cyc - 1)) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Model state
    logic        m_rr = 1'b0;
    logic [31:0] m_lpc = 32'd0;
    logic [31:0] m_last1 = 32'd0;
    logic [31:0] m_last3 = 32'd0;
    logic [31:0] m_cnt0 = 32'd0;
    logic [31:0] m_cnt1 = 32'd0;

    // Compare process: every falling edge, predict and check all outputs
    initial begin
        logic [1:0]  el, eg, s1, s3;
        logic [31:0] epc;
        forever begin
            @(negedge clk);
            el = req & ~flush;
            eg = 2'b00;
            if (!rst) begin
                case (el)
                    2'b01:   eg = 2'b01;
                    2'b10:   eg = 2'b10;
                    2'b11:   eg = m_rr ? 2'b10 : 2'b01;
                    default: eg = 2'b00;
                endcase
            end
            epc = eg[1] ? pc1 : (eg[0] ? pc0 : m_lpc);
            g_v[cyc]  = |eg;
            g_id[cyc] = eg[1];
            g_pc[cyc] = epc;
            kill[cyc] = rst ? 2'b11 : flush;
            s1 = strobe(1);
            s3 = strobe(3);
            chk("gnt_l1", {30'd0, gnt1}, {30'd0, eg});
            chk("gnt_l3", {30'd0, gnt3}, {30'd0, eg});
            chk("rsp_valid_l1", {30'd0, rv1}, {30'd0, s1});
            chk("rsp_valid_l3", {30'd0, rv3}, {30'd0, s3});
            if (!rst) begin
                if (s1 != 2'b00) m_last1 = stub(g_pc[cyc - 2]);
                if (s3 != 2'b00) m_last3 = stub(g_pc[cyc - 4]);
                chk("dec_pc_l1", dpc1, epc);
                chk("dec_pc_l3", dpc3, epc);
                chk("rsp_instr_l1", ri1, m_last1);
                chk("rsp_instr_l3", ri3, m_last3);
                chk("busy_l1", {31'd0, busy1}, {31'd0, busy_exp(1)});
                chk("busy_l3", {31'd0, busy3}, {31'd0, busy_exp(3)});
`ifdef DECOMP_ARB_STATS_EN
                chk("cnt0_l1", c01, m_cnt0);
                chk("cnt1_l1", c11, m_cnt1);
                chk("cnt0_l3", c03, m_cnt0);
                chk("cnt1_l3", c13, m_cnt1);
`endif
            end
            if (rst) begin
                m_rr = 1'b0; m_lpc = 32'd0; m_last1 = 32'd0; m_last3 = 32'd0;
                m_cnt0 = 32'd0; m_cnt1 = 32'd0;
            end else if (eg != 2'b00) begin
                m_rr  = ~eg[1];
                m_lpc = epc;
                if (eg[0] && m_cnt0 != 32'hFFFF_FFFF) m_cnt0 = m_cnt0 + 32'd1;
                if (eg[1] && m_cnt1 != 32'hFFFF_FFFF) m_cnt1 = m_cnt1 + 32'd1;
            end
            cyc++;
            if (cyc >= MAXC) begin
                $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC);
                $fatal(1);
            end
        end
    end

    // Apply one cycle of inputs just after the rising edge, then wait for the falling edge
    task automatic drv(input logic [1:0] r, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] f, input logic rs);
        @(posedge clk);
        #1;
        req = r; pc0 = a; pc1 = b; flush = f; rst = rs;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(2'b00, 32'd0, 32'd0, 2'b00, 1'b0);
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; flush = 2'b00; pc0 = 32'd0; pc1 = 32'd0;
        for (int i = 0; i < 3; i++) drv(2'b00, 32'd0, 32'd0, 2'b00, 1'b1);

        // Single requester streaming 0x0, 0x4, 0x8
        drv(2'b01, 32'h0, 32'd0, 2'b00, 1'b0);
        chk("lit_gnt_a", {30'd0, gnt1}, 32'd1);
        drv(2'b01, 32'h4, 32'd0, 2'b00, 1'b0);
        chk("lit_gnt_b", {30'd0, gnt1}, 32'd1);
        drv(2'b01, 32'h8, 32'd0, 2'b00, 1'b0);
        chk("lit_rsp_valid_first", {30'd0, rv1}, 32'd1);
        chk("lit_rsp_instr_first", ri1, 32'h0000_FFFF);
        idle(5);

        // Contention after reset starts with requester 0 and alternates
        drv(2'b00, 32'd0, 32'd0, 2'b00, 1'b1);
        drv(2'b11, 32'h100, 32'h200, 2'b00, 1'b0);
        chk("lit_rr_0", {30'd0, gnt1}, 32'd1);
        chk("lit_rr_pc0", dpc1, 32'h100);
        drv(2'b11, 32'h100, 32'h200, 2'b00, 1'b0);
        chk("lit_rr_1", {30'd0, gnt1}, 32'd2);
        chk("lit_rr_pc1", dpc1, 32'h200);
        drv(2'b11, 32'h100, 32'h200, 2'b00, 1'b0);
        chk("lit_rr_2", {30'd0, gnt1}, 32'd1);
        drv(2'b11, 32'h100, 32'h200, 2'b00, 1'b0);
        chk("lit_rr_3", {30'd0, gnt1}, 32'd2);
        idle(4);

        // Flush requester 1 with three lookups in flight; requester 0 keeps going
        drv(2'b10, 32'd0, 32'h300, 2'b00, 1'b0);
        drv(2'b10, 32'd0, 32'h304, 2'b00, 1'b0);
        drv(2'b10, 32'd0, 32'h308, 2'b00, 1'b0);
        drv(2'b01, 32'h40, 32'd0, 2'b10, 1'b0);
        idle(5);
        chk("lit_busy_drained", {31'd0, busy3}, 32'd0);

        // Flush in the exact response cycle, then flush one cycle too late
        drv(2'b01, 32'h500, 32'd0, 2'b00, 1'b0);
        idle(1);
        drv(2'b00, 32'd0, 32'd0, 2'b01, 1'b0);
        chk("lit_flush_resp_cycle", {30'd0, rv1}, 32'd0);
        idle(4);
        drv(2'b01, 32'h504, 32'd0, 2'b00, 1'b0);
        idle(1);
        drv(2'b00, 32'd0, 32'd0, 2'b00, 1'b0);
        chk("lit_resp_504_valid", {30'd0, rv1}, 32'd1);
        chk("lit_resp_504_instr", ri1, 32'h0504_FAFB);
        drv(2'b00, 32'd0, 32'd0, 2'b01, 1'b0);
        chk("lit_late_flush_valid", {30'd0, rv1}, 32'd0);
        chk("lit_late_flush_hold", ri1, 32'h0504_FAFB);
        idle(4);

        // Reset with lookups in flight
        drv(2'b11, 32'h600, 32'h700, 2'b00, 1'b0);
        drv(2'b11, 32'h600, 32'h700, 2'b00, 1'b0);
        drv(2'b00, 32'd0, 32'd0, 2'b00, 1'b1);
        idle(1);
        chk("lit_reset_dec_pc", dpc3, 32'd0);
        chk("lit_reset_busy", {31'd0, busy3}, 32'd0);
        idle(4);
        drv(2'b11, 32'h800, 32'h900, 2'b00, 1'b0);
        chk("lit_reset_rr", {30'd0, gnt3}, 32'd1);
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
